// File: rtl/iot_bus_mux_if.sv
// IOT bus bundle between the CPU, the IOT multiplexer and its device channels.
// master = CPU/device side, slave = multiplexer side.
interface iot_bus_mux_if #(
    parameter int NDEV = 4
);
    logic [4:0]         state;
    logic [0:11]        instruction;
    logic [11:0]        ac;
    logic [NDEV*12-1:0] dev_in_bus;
    logic [NDEV-1:0]    dev_skip;
    logic [NDEV-1:0]    dev_wait;
    logic [NDEV-1:0]    iot_strobe;
    logic [2:0]         io_op;
    logic               io_stall;
    logic [11:0]        in_bus;
    logic               skip;
    logic [11:0]        bus_display;
    logic               timeout_err;

    modport master (
        output state, instruction, ac,
        output dev_in_bus, dev_skip, dev_wait,
        input  iot_strobe, io_op, io_stall,
        input  in_bus, skip, bus_display, timeout_err
    );

    modport slave (
        input  state, instruction, ac,
        input  dev_in_bus, dev_skip, dev_wait,
        output iot_strobe, io_op, io_stall,
        output in_bus, skip, bus_display, timeout_err
    );
endinterface

// File: rtl/iot_bus_mux.sv
// IOT multiplexer: decodes the device field, strobes one channel,
// stretches F2 while the device waits and registers its reply.
module iot_bus_mux #(
    parameter int                NDEV       = 4,
    parameter logic [NDEV*6-1:0] DEV_CODES  = {6'o74, 6'o04, 6'o03, 6'o00},
    parameter logic [NDEV*8-1:0] DEV_RDMASK = {8'h60, 8'h00, 8'h54, 8'h10},
    parameter int                TIMEOUT    = 64,
    parameter logic [4:0]        F1         = 5'd1,
    parameter logic [4:0]        F2         = 5'd2,
    parameter logic [4:0]        F3         = 5'd3
) (
    input  logic         clk,
    input  logic         reset,
    iot_bus_mux_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_SEL, S_WAIT, S_DONE
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [2:0]       op_q, op_d;
    logic [11:0]      ac_q, ac_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      in_bus_q, in_bus_d;
    logic             skip_q, skip_d;
    logic [11:0]      disp_q, disp_d;
    logic             terr_q, terr_d;

    logic             f1, f2, f3, is_iot, hit, strobe_on;
    logic [SEL_W-1:0] hit_idx;
    logic [11:0]      sel_data;
    logic             sel_skip, sel_wait;
    logic [7:0]       sel_mask;
    logic [NDEV-1:0]  sel_hot;

    assign f1     = bus.state == F1;
    assign f2     = bus.state == F2;
    assign f3     = bus.state == F3;
    assign is_iot = bus.instruction[0:2] == 3'o6;

    // descending scan so the lowest matching channel is the last writer
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (bus.instruction[3:8] == DEV_CODES[6*k +: 6]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_skip = 1'b0;
        sel_wait = 1'b0;
        sel_mask = '0;
        sel_hot  = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_data   = bus.dev_in_bus[12*k +: 12];
                sel_skip   = bus.dev_skip[k];
                sel_wait   = bus.dev_wait[k];
                sel_mask   = DEV_RDMASK[8*k +: 8];
                sel_hot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        sel_d    = sel_q;
        op_d     = op_q;
        ac_d     = ac_q;
        cnt_d    = cnt_q;
        in_bus_d = in_bus_q;
        skip_d   = skip_q;
        disp_d   = disp_q;
        terr_d   = terr_q;
        if (fsm_q != S_IDLE && f1) begin
            // CPU started a new cycle under us
            fsm_d    = S_IDLE;
            in_bus_d = '0;
            skip_d   = 1'b0;
            terr_d   = 1'b1;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    in_bus_d = '0;
                    skip_d   = 1'b0;
                    if (f1 && is_iot && hit) begin
                        fsm_d = S_SEL;
                        sel_d = hit_idx;
                        op_d  = bus.instruction[9:11];
                    end
                end
                S_SEL: begin
                    if (f2) begin
                        ac_d  = bus.ac;
                        cnt_d = '0;
                        if (sel_wait) begin
                            fsm_d = S_WAIT;
                        end else begin
                            fsm_d    = S_DONE;
                            in_bus_d = sel_data;
                            skip_d   = sel_skip;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!sel_wait) begin
                        fsm_d    = S_DONE;
                        in_bus_d = sel_data;
                        skip_d   = sel_skip;
                    end else if (cnt_q == CNT_LAST) begin
                        fsm_d    = S_DONE;
                        in_bus_d = '0;
                        skip_d   = 1'b0;
                        terr_d   = 1'b1;
                    end
                end
                S_DONE: begin
                    if (f3) begin
                        disp_d = sel_mask[op_q] ? in_bus_q : ac_q;
                        fsm_d  = S_IDLE;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q    <= S_IDLE;
            sel_q    <= '0;
            op_q     <= '0;
            ac_q     <= '0;
            cnt_q    <= '0;
            in_bus_q <= '0;
            skip_q   <= 1'b0;
            disp_q   <= '0;
            terr_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            ac_q     <= ac_d;
            cnt_q    <= cnt_d;
            in_bus_q <= in_bus_d;
            skip_q   <= skip_d;
            disp_q   <= disp_d;
            terr_q   <= terr_d;
        end
    end

    assign strobe_on       = (fsm_q == S_SEL) && f2;
    assign bus.iot_strobe  = strobe_on ? sel_hot : '0;
    assign bus.io_op       = strobe_on ? op_q : 3'b000;
    assign bus.io_stall    = fsm_q == S_WAIT;
    assign bus.in_bus      = in_bus_q;
    assign bus.skip        = skip_q;
    assign bus.bus_display = disp_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_iot_bus_mux.sv
// Bench for iot_bus_mux: directed IOT scenarios plus random IOT
// transactions against a transaction-level model of the mux.
module tb_iot_bus_mux;
    localparam int         NDEV = 4;
    localparam int         TMO  = 64;
    localparam logic [4:0] F1   = 5'd1;
    localparam logic [4:0] F2   = 5'd2;
    localparam logic [4:0] F3   = 5'd3;
    localparam logic [23:0] CODES_A = {6'o74, 6'o04, 6'o03, 6'o00};
    localparam logic [23:0] CODES_B = {6'o03, 6'o04, 6'o03, 6'o00};
    localparam logic [31:0] RDMASK  = {8'h60, 8'h00, 8'h54, 8'h10};

    logic [5:0] tbl_a [4] = '{6'o00, 6'o03, 6'o04, 6'o74};
    logic [5:0] tbl_b [4] = '{6'o00, 6'o03, 6'o04, 6'o03};
    logic [7:0] rd_tbl [4] = '{8'h10, 8'h54, 8'h00, 8'h60};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    iot_bus_mux_if #(.NDEV(NDEV)) b ();
    iot_bus_mux_if #(.NDEV(NDEV)) b2 ();

    iot_bus_mux #(
        .NDEV(NDEV), .DEV_CODES(CODES_A), .DEV_RDMASK(RDMASK),
        .TIMEOUT(TMO), .F1(F1), .F2(F2), .F3(F3)
    ) dut (.clk(clk), .reset(rst_n), .bus(b));

    iot_bus_mux #(
        .NDEV(NDEV), .DEV_CODES(CODES_B), .DEV_RDMASK(RDMASK),
        .TIMEOUT(TMO), .F1(F1), .F2(F2), .F3(F3)
    ) dut2 (.clk(clk), .reset(rst_n), .bus(b2));

    assign b2.state       = b.state;
    assign b2.instruction = b.instruction;
    assign b2.ac          = b.ac;
    assign b2.dev_in_bus  = b.dev_in_bus;
    assign b2.dev_skip    = b.dev_skip;
    assign b2.dev_wait    = '0;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [11:0] data [4];
    logic [3:0]  skp;
    logic [11:0] m_disp = '0;
    logic        m_terr = 1'b0;

    typedef struct {
        logic [3:0]  strobe, strobe2;
        logic [2:0]  op;
        int          stall;
        logic        extra, hung;
        logic [11:0] bus_done, bus_f3, disp, bus_idle;
        logic        skip_done, skip_idle, terr;
    } obs_t;

    typedef struct {
        logic [3:0]  strobe, strobe2;
        logic [2:0]  op;
        int          stall;
        logic [11:0] dbus, disp;
        logic        skip, terr;
    } exp_t;

    function automatic int find_ch(input logic [0:11] ins, input bit use_b);
        if (ins[0:2] != 3'o6) return -1;
        for (int k = 0; k < 4; k++)
            if ((use_b ? tbl_b[k] : tbl_a[k]) == ins[3:8]) return k;
        return -1;
    endfunction

    function automatic exp_t predict(input logic [0:11] ins,
                                     input logic [11:0] acv, input int wl);
        exp_t e;
        int   ch = find_ch(ins, 1'b0);
        int   ch2 = find_ch(ins, 1'b1);
        bit   to = wl > TMO;
        e.strobe = '0;
        e.strobe2 = '0;
        if (ch2 >= 0) e.strobe2[ch2] = 1'b1;
        if (ch < 0) begin
            e.op = 3'b0; e.stall = 0; e.dbus = '0; e.skip = 1'b0;
        end else begin
            e.strobe[ch] = 1'b1;
            e.op    = ins[9:11];
            e.stall = to ? TMO : wl;
            e.dbus  = to ? 12'o0 : data[ch];
            e.skip  = to ? 1'b0 : skp[ch];
            m_disp  = rd_tbl[ch][ins[9:11]] ? e.dbus : acv;
            if (to) m_terr = 1'b1;
        end
        e.disp = m_disp;
        e.terr = m_terr;
        return e;
    endfunction

    task automatic set_dev();
        for (int k = 0; k < 4; k++) b.dev_in_bus[12*k +: 12] = data[k];
        b.dev_skip = skp;
    endtask

    task automatic rand_dev();
        for (int k = 0; k < 4; k++) data[k] = 12'($urandom);
        skp = 4'($urandom);
        set_dev();
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        b.state = 5'd0; b.dev_wait = '0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_disp = '0; m_terr = 1'b0;
    endtask

    // One full F1/F2(stretched)/F3 cycle; dev_wait[wch] is held high
    // for the first wl cycles counted from the strobe cycle.
    task automatic do_iot(input logic [0:11] ins, input logic [11:0] acv,
                          input int wl, input int wch, output obs_t o);
        logic [3:0] dw;
        int i;
        @(posedge clk); #1;
        b.state = F1; b.instruction = ins; b.ac = acv;
        b.dev_wait = 4'($urandom);
        @(posedge clk); #1;
        b.state = F2;
        dw = 4'($urandom); dw[wch] = wl > 0; b.dev_wait = dw;
        @(negedge clk);
        o.strobe = b.iot_strobe; o.op = b.io_op; o.strobe2 = b2.iot_strobe;
        o.stall = 0; o.extra = 1'b0; o.hung = 1'b0;
        i = 1;
        while (1) begin
            @(posedge clk); #1;
            dw = 4'($urandom); dw[wch] = i < wl; b.dev_wait = dw;
            b.ac = 12'($urandom);
            @(negedge clk);
            if (b.iot_strobe != '0) o.extra = 1'b1;
            if (!b.io_stall) break;
            o.stall++;
            if (i > 200) begin o.hung = 1'b1; break; end
            i++;
        end
        o.bus_done = b.in_bus; o.skip_done = b.skip; o.terr = b.timeout_err;
        @(posedge clk); #1;
        b.state = F3;
        b.dev_in_bus = 48'({$urandom, $urandom}); b.dev_skip = 4'($urandom);
        @(negedge clk);
        o.bus_f3 = b.in_bus;
        @(posedge clk); #1;
        b.state = 5'd0;
        @(negedge clk);
        o.disp = b.bus_display;
        @(negedge clk);
        o.bus_idle = b.in_bus; o.skip_idle = b.skip;
    endtask

    task automatic test_reset();
        b.state = 5'd0; b.instruction = '0; b.ac = '0;
        b.dev_in_bus = '0; b.dev_skip = '0; b.dev_wait = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({b.iot_strobe, b.io_op, b.io_stall} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_strobe got=%b/%o/%b exp=0", b.iot_strobe, b.io_op, b.io_stall);
        end
        n_chk++;
        if ({b.in_bus, b.skip, b.bus_display, b.timeout_err} !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_regs got in=%o sk=%b d=%o t=%b exp=0", b.in_bus, b.skip, b.bus_display, b.timeout_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (b.io_stall !== 1'b0 || b.in_bus !== 12'o0) begin
            n_fail++;
            $display("FAIL post_reset got stall=%b in=%o exp=0", b.io_stall, b.in_bus);
        end
    endtask

    task automatic test_basic();
        obs_t o; exp_t e;
        rand_dev(); data[1] = 12'o0215; set_dev();
        e = predict(12'o6034, 12'o7777, 0);
        do_iot(12'o6034, 12'o7777, 0, 1, o);
        n_chk++;
        if (o.strobe !== 4'b0010 || o.op !== 3'o4) begin
            n_fail++; $display("FAIL b6034_strobe got=%b/%o exp=0010/4", o.strobe, o.op);
        end
        n_chk++;
        if (o.bus_done !== 12'o0215 || o.skip_done !== skp[1]) begin
            n_fail++; $display("FAIL b6034_data got=%o/%b exp=0215/%b", o.bus_done, o.skip_done, skp[1]);
        end
        n_chk++;
        if (o.disp !== 12'o0215 || o.extra !== 1'b0) begin
            n_fail++; $display("FAIL b6034_disp got=%o extra=%b exp=0215/0", o.disp, o.extra);
        end
        rand_dev(); data[2] = 12'o0; set_dev();
        e = predict(12'o6046, 12'o0301, 0);
        do_iot(12'o6046, 12'o0301, 0, 2, o);
        n_chk++;
        if (o.strobe !== 4'b0100 || o.op !== 3'o6) begin
            n_fail++; $display("FAIL b6046_strobe got=%b/%o exp=0100/6", o.strobe, o.op);
        end
        n_chk++;
        if (o.disp !== 12'o0301 || o.bus_done !== 12'o0) begin
            n_fail++; $display("FAIL b6046_disp got=%o in=%o exp=0301/0", o.disp, o.bus_done);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o; exp_t e;
        rand_dev();
        @(posedge clk); #1;
        b.state = F1; b.instruction = 12'o6741; b.ac = 12'o1234; b.dev_wait = '0;
        @(posedge clk); #1;
        b.state = F2; b.dev_wait = 4'b1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (b.io_stall !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_stall got=%b exp=1", b.io_stall);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({b.iot_strobe, b.io_op, b.io_stall, b.in_bus, b.skip, b.bus_display, b.timeout_err} !== 34'h0) begin
            n_fail++;
            $display("FAIL async_reset got st=%b s=%b in=%o d=%o t=%b exp=0", b.iot_strobe, b.io_stall, b.in_bus, b.bus_display, b.timeout_err);
        end
        b.dev_wait = '0; b.state = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        m_disp = '0; m_terr = 1'b0;
        e = predict(12'o6034, 12'o0, 0);
        do_iot(12'o6034, 12'o0, 0, 1, o);
        n_chk++;
        if (o.strobe !== 4'b0010 || o.bus_done !== data[1]) begin
            n_fail++; $display("FAIL after_reset got=%b/%o exp=0010/%o", o.strobe, o.bus_done, data[1]);
        end
    endtask

    task automatic test_wait();
        obs_t o; exp_t e;
        rand_dev();
        e = predict(12'o6745, 12'o4321, 5);
        do_iot(12'o6745, 12'o4321, 5, 3, o);
        n_chk++;
        if (o.stall !== 5 || o.hung) begin
            n_fail++; $display("FAIL wait5_stall got=%0d exp=5", o.stall);
        end
        n_chk++;
        if (o.bus_done !== data[3] || o.bus_f3 !== data[3]) begin
            n_fail++; $display("FAIL wait5_data got=%o/%o exp=%o", o.bus_done, o.bus_f3, data[3]);
        end
        n_chk++;
        if (o.terr !== 1'b0 || o.disp !== data[3]) begin
            n_fail++; $display("FAIL wait5_disp got=%o t=%b exp=%o/0", o.disp, o.terr, data[3]);
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        rand_dev();
        e = predict(12'o6741, 12'o0111, 64);
        do_iot(12'o6741, 12'o0111, 64, 3, o);
        n_chk++;
        if (o.stall !== 64 || o.terr !== 1'b0 || o.bus_done !== data[3]) begin
            n_fail++; $display("FAIL fall63 got stall=%0d t=%b in=%o exp=64/0/%o", o.stall, o.terr, o.bus_done, data[3]);
        end
        rand_dev();
        e = predict(12'o6741, 12'o0222, 1000);
        do_iot(12'o6741, 12'o0222, 1000, 3, o);
        n_chk++;
        if (o.stall !== 64 || o.hung) begin
            n_fail++; $display("FAIL timeout_stall got=%0d exp=64", o.stall);
        end
        n_chk++;
        if (o.terr !== 1'b1 || o.skip_done !== 1'b0 || o.bus_done !== 12'o0) begin
            n_fail++; $display("FAIL timeout_err got t=%b sk=%b in=%o exp=1/0/0", o.terr, o.skip_done, o.bus_done);
        end
        n_chk++;
        if (o.disp !== 12'o0222) begin
            n_fail++; $display("FAIL timeout_disp got=%o exp=0222", o.disp);
        end
    endtask

    task automatic test_nop();
        obs_t o; exp_t e;
        logic [11:0] old_disp;
        rand_dev();
        old_disp = m_disp;
        e = predict(12'o6214, 12'o5555, 3);
        do_iot(12'o6214, 12'o5555, 3, 0, o);
        n_chk++;
        if (o.strobe !== 4'b0 || o.stall !== 0 || o.extra) begin
            n_fail++; $display("FAIL nop_strobe got=%b stall=%0d exp=0/0", o.strobe, o.stall);
        end
        n_chk++;
        if (o.bus_done !== 12'o0 || o.skip_done !== 1'b0 || o.disp !== old_disp) begin
            n_fail++; $display("FAIL nop_data got in=%o sk=%b d=%o exp=0/0/%o", o.bus_done, o.skip_done, o.disp, old_disp);
        end
        n_chk++;
        if (o.terr !== 1'b1) begin
            n_fail++; $display("FAIL sticky_err got=%b exp=1", o.terr);
        end
        rand_dev();
        e = predict(12'o6034, 12'o0, 0);
        do_iot(12'o6034, 12'o0, 0, 1, o);
        n_chk++;
        if (o.strobe2 !== 4'b0010) begin
            n_fail++; $display("FAIL dup_lowest got=%b exp=0010", o.strobe2);
        end
    endtask

    task automatic test_abort();
        obs_t o; exp_t e;
        apply_reset();
        rand_dev();
        @(posedge clk); #1;
        b.state = F1; b.instruction = 12'o6034; b.dev_wait = 4'b0010;
        @(posedge clk); #1;
        b.state = F2;
        @(posedge clk); #1;
        b.state = F1;
        @(negedge clk);
        n_chk++;
        if (b.io_stall !== 1'b1 || b.timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre got s=%b t=%b exp=1/0", b.io_stall, b.timeout_err);
        end
        @(posedge clk); #1;
        b.state = F2;
        @(negedge clk);
        n_chk++;
        if (b.io_stall !== 1'b0 || b.iot_strobe !== 4'b0 || b.timeout_err !== 1'b1 || b.in_bus !== 12'o0) begin
            n_fail++;
            $display("FAIL abort got s=%b st=%b t=%b in=%o exp=0/0000/1/0", b.io_stall, b.iot_strobe, b.timeout_err, b.in_bus);
        end
        m_terr = 1'b1;
        @(posedge clk); #1;
        b.state = 5'd0; b.dev_wait = '0;
        e = predict(12'o6034, 12'o0, 0);
        do_iot(12'o6034, 12'o0, 0, 1, o);
        n_chk++;
        if (o.strobe !== 4'b0010 || o.bus_done !== data[1]) begin
            n_fail++; $display("FAIL after_abort got=%b/%o exp=0010/%o", o.strobe, o.bus_done, data[1]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            logic [0:11] ins;
            logic [11:0] acv;
            logic [5:0]  code;
            logic [2:0]  top;
            int          r, wl, ch;
            exp_t        e;
            obs_t        o;
            r = $urandom_range(0, 4);
            code = (r == 4) ? 6'($urandom) : tbl_a[r];
            top = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'o6;
            ins = {top, code, 3'($urandom)};
            acv = 12'($urandom);
            r = $urandom_range(0, 9);
            wl = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 6) :
                 (r == 8) ? $urandom_range(63, 65) : 200;
            rand_dev();
            ch = find_ch(ins, 1'b0);
            e = predict(ins, acv, wl);
            do_iot(ins, acv, wl, (ch < 0) ? 0 : ch, o);
            n_chk++;
            if (o.strobe !== e.strobe || o.op !== e.op) begin
                n_fail++; $display("FAIL rnd_strobe t=%0d ins=%o got=%b/%o exp=%b/%o", t, ins, o.strobe, o.op, e.strobe, e.op);
            end
            n_chk++;
            if (o.strobe2 !== e.strobe2) begin
                n_fail++; $display("FAIL rnd_strobe2 t=%0d got=%b exp=%b", t, o.strobe2, e.strobe2);
            end
            n_chk++;
            if (o.stall !== e.stall || o.hung || o.extra) begin
                n_fail++; $display("FAIL rnd_stall t=%0d got=%0d extra=%b exp=%0d", t, o.stall, o.extra, e.stall);
            end
            n_chk++;
            if (o.bus_done !== e.dbus || o.bus_f3 !== e.dbus) begin
                n_fail++; $display("FAIL rnd_in_bus t=%0d got=%o/%o exp=%o", t, o.bus_done, o.bus_f3, e.dbus);
            end
            n_chk++;
            if (o.skip_done !== e.skip) begin
                n_fail++; $display("FAIL rnd_skip t=%0d got=%b exp=%b", t, o.skip_done, e.skip);
            end
            n_chk++;
            if (o.terr !== e.terr) begin
                n_fail++; $display("FAIL rnd_terr t=%0d got=%b exp=%b", t, o.terr, e.terr);
            end
            n_chk++;
            if (o.disp !== e.disp) begin
                n_fail++; $display("FAIL rnd_disp t=%0d got=%o exp=%o", t, o.disp, e.disp);
            end
            n_chk++;
            if (o.bus_idle !== 12'o0 || o.skip_idle !== 1'b0) begin
                n_fail++; $display("FAIL rnd_idle_clr t=%0d got=%o/%b exp=0/0", t, o.bus_idle, o.skip_idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_wait();
        test_wait();
        test_timeout();
        test_nop();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
